// File: rtl/ib_mul_pkg.sv
// Shared types and helpers for the iterative NxN multiplier.
package ib_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int STEP_DEF  = 2;
    localparam int ITER      = WIDTH_DEF / STEP_DEF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int iter_count(input int width, input int step);
        return width / step;
    endfunction

endpackage

// File: rtl/ib_mul_pp_step.sv
// Partial-product term for one STEP-bit multiplier group; the caller applies the group shift.
module ib_mul_pp_step
    import ib_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [STEP-1:0]    b_slice,
    input  logic               mode,
    input  logic               last,
    output logic [2*WIDTH-1:0] term
);

    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};

    // In signed mode the top bit of the top group carries negative weight.
    always_comb begin
        term = '0;
        for (int j = 0; j < STEP; j++) begin
            if (b_slice[j]) begin
                if (mode && last && (j == STEP - 1))
                    term = term - (a_ext << j);
                else
                    term = term + (a_ext << j);
            end
        end
    end

endmodule

// File: rtl/ib_mul_nxn_seq.sv
// Radix-2^STEP shift-add multiplier with signed/unsigned mode and start/done handshake.
//   state | meaning
//   IDLE  | waiting for i_start, result held on o_c
//   RUN   | retiring STEP multiplier bits per cycle into acc
//   DONE  | registered result cycle, o_done high (REG_OUT=1 only)
module ib_mul_nxn_seq
    import ib_mul_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP    = 2,
    parameter int REG_OUT = 1
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_c,
    output logic               o_done,
    output logic               o_busy
);

    localparam int ITER_N = iter_count(WIDTH, STEP);
    localparam int CNT_W  = (clog2(ITER_N) < 1) ? 1 : clog2(ITER_N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_N - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] c_q;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;

    logic               last_grp;
    logic               last_iter;
    logic               accept;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_next;

    assign last_grp  = (cnt == LAST_CNT);
    assign last_iter = (state == RUN) && last_grp;

    // A start in the done cycle counts as idle, giving back-to-back throughput.
    assign accept = i_start && ((state == IDLE) || (state == DONE) ||
                                ((REG_OUT == 0) && last_iter));

    ib_mul_pp_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_pp_step (
        .a       (a_q),
        .b_slice (b_q[STEP-1:0]),
        .mode    (mode_q),
        .last    (last_grp),
        .term    (pp)
    );

    assign acc_next = acc + (pp << (STEP * int'(cnt)));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            acc    <= '0;
            c_q    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                RUN: begin
                    acc <= acc_next;
                    b_q <= b_q >> STEP;
                    cnt <= cnt + CNT_W'(1);
                    if (last_grp) begin
                        c_q <= acc_next;
                        if (REG_OUT != 0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (accept) begin
                a_q    <= i_a;
                b_q    <= i_b;
                mode_q <= i_signed;
                acc    <= '0;
                cnt    <= '0;
                state  <= RUN;
            end
        end
    end

    assign o_done = (REG_OUT != 0) ? done_q : last_iter;
    assign o_c    = ((REG_OUT == 0) && last_iter) ? acc_next : c_q;
    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_ib_mul_nxn_seq.sv
// Bench for ib_mul_nxn_seq: directed and random checks on the default build plus WIDTH=16 variants.
module tb_ib_mul_nxn_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst16_n;
    logic        start;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic        done;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cfg_finished = 0;

    ib_mul_nxn_seq u_dut (
        .i_clk    (clk),
        .i_nrst   (rst_n),
        .i_start  (start),
        .i_signed (sgn),
        .i_a      (a),
        .i_b      (b),
        .o_c      (c),
        .o_done   (done),
        .o_busy   (busy)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Exact product of w-bit operands, read as signed or unsigned, kept to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] x_in, input logic [31:0] y_in,
                                            input logic is_signed, input int w);
        longint x, y, p;
        logic [63:0] r;
        x = longint'({32'd0, x_in}) & ((longint'(1) << w) - 1);
        y = longint'({32'd0, y_in}) & ((longint'(1) << w) - 1);
        if (is_signed && x_in[w-1]) x = x - (longint'(1) << w);
        if (is_signed && y_in[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        r = p;
        return r & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          input logic [15:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        a = x; b = y; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sgn = ~s;
        chk_eq({tag, "_busy1"}, 64'(busy), 64'd1);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq({tag, "_lat"}, 64'(cyc), 64'd5);
        chk_eq({tag, "_c"}, 64'(c), 64'(exp));
        chk_eq({tag, "_busy_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk_eq({tag, "_pulse"}, 64'(done), 64'd0);
        chk_eq({tag, "_hold"}, 64'(c), 64'(exp));
    endtask

    // WIDTH=16 builds covering every STEP / REG_OUT pairing, each with its own driver.
    localparam int CFG_STEP [6] = '{1, 2, 4, 1, 2, 4};
    localparam int CFG_REG  [6] = '{0, 0, 0, 1, 1, 1};

    for (genvar g = 0; g < 6; g++) begin : cfg
        localparam int S   = CFG_STEP[g];
        localparam int R   = CFG_REG[g];
        localparam int LAT = 16 / S + R;

        logic        start_g;
        logic        sgn_g;
        logic [15:0] a_g;
        logic [15:0] b_g;
        logic [31:0] c_g;
        logic        done_g;
        logic        busy_g;

        ib_mul_nxn_seq #(
            .WIDTH   (16),
            .STEP    (S),
            .REG_OUT (R)
        ) u_dut16 (
            .i_clk    (clk),
            .i_nrst   (rst16_n),
            .i_start  (start_g),
            .i_signed (sgn_g),
            .i_a      (a_g),
            .i_b      (b_g),
            .o_c      (c_g),
            .o_done   (done_g),
            .o_busy   (busy_g)
        );

        initial begin
            logic [63:0] exp;
            int cyc;
            bit poke;
            start_g = 1'b0; sgn_g = 1'b0; a_g = '0; b_g = '0;
            repeat (6) @(negedge clk);
            for (int i = 0; i < 300; i++) begin
                a_g = 16'($urandom); b_g = 16'($urandom);
                sgn_g = 1'($urandom_range(0, 1));
                if (i == 0) begin a_g = 16'h8000; b_g = 16'h8000; sgn_g = 1'b1; end
                if (i == 1) begin a_g = 16'h8000; b_g = 16'hFFFF; sgn_g = 1'b1; end
                if (i == 2) begin a_g = 16'hFFFF; b_g = 16'hFFFF; sgn_g = 1'b0; end
                if (i == 3) begin a_g = 16'h0000; b_g = 16'h1234; end
                exp = ref_mul({16'd0, a_g}, {16'd0, b_g}, sgn_g, 16);
                poke = ($urandom_range(0, 3) == 0);
                start_g = 1'b1;
                @(negedge clk);
                start_g = 1'b0;
                a_g = 16'($urandom); b_g = 16'($urandom);
                cyc = 1;
                while (!done_g && cyc < LAT + 10) begin
                    @(negedge clk);
                    cyc++;
                    start_g = poke && (cyc == 2);
                end
                start_g = 1'b0;
                chk_eq($sformatf("cfg%0d_lat", g), 64'(cyc), 64'(LAT));
                chk_eq($sformatf("cfg%0d_c", g), 64'(c_g), exp);
                chk_eq($sformatf("cfg%0d_busy", g), 64'(busy_g), 64'd1);
                @(negedge clk);
                chk_eq($sformatf("cfg%0d_pulse", g), 64'(done_g), 64'd0);
                chk_eq($sformatf("cfg%0d_hold", g), 64'(c_g), exp);
            end
            cfg_finished++;
        end
    end

    initial begin
        logic [63:0] r;
        logic [7:0]  x, y;
        logic        s;
        logic [15:0] cval;
        int cyc, ndone, dcyc;

        rst_n = 1'b0; rst16_n = 1'b0;
        start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_c", 64'(c), 64'd0);
        chk_eq("rst_done", 64'(done), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1; rst16_n = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 16'h0000, "zero");
        run_op(8'h00, 8'hAB, 1'b1, 16'h0000, "zero_s");
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "umax");
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, "smin_smin");
        run_op(8'hFF, 8'h02, 1'b1, 16'hFFFE, "sm1_2");
        run_op(8'h80, 8'hFF, 1'b1, 16'h0080, "smin_m1");
        run_op(8'hFF, 8'h80, 1'b1, 16'h0080, "m1_smin");
        run_op(8'h7F, 8'h80, 1'b1, 16'hC080, "smax_smin");

        for (int i = 0; i < 150; i++) begin
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom_range(0, 1));
            r = ref_mul({24'd0, x}, {24'd0, y}, s, 8);
            run_op(x, y, s, r[15:0], "rnd");
        end

        // start while busy must be ignored
        @(negedge clk);
        a = 8'd3; b = 8'd5; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        ndone = 0; dcyc = 0; cval = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin a = 8'd7; b = 8'd7; start = 1'b1; end
            else start = 1'b0;
            if (k <= 5) chk_eq("busy_hold", 64'(busy), 64'd1);
            if (done) begin ndone++; dcyc = k; cval = c; end
            @(negedge clk);
        end
        start = 1'b0;
        chk_eq("sb_ndone", 64'(ndone), 64'd1);
        chk_eq("sb_lat", 64'(dcyc), 64'd5);
        chk_eq("sb_c", 64'(cval), 64'd15);

        // back-to-back: start accepted in the done cycle
        a = 8'd12; b = 8'd10; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin @(negedge clk); cyc++; end
        chk_eq("b2b_lat1", 64'(cyc), 64'd5);
        chk_eq("b2b_c1", 64'(c), 64'd120);
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("b2b_nobubble", 64'(busy), 64'd1);
        chk_eq("b2b_pulse", 64'(done), 64'd0);
        cyc = 1;
        while (!done && cyc < 20) begin @(negedge clk); cyc++; end
        chk_eq("b2b_lat2", 64'(cyc), 64'd5);
        chk_eq("b2b_c2", 64'(c), 64'd81);

        // reset mid-run discards the operation
        @(negedge clk);
        a = 8'd200; b = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("mrst_c", 64'(c), 64'd0);
        chk_eq("mrst_busy", 64'(busy), 64'd0);
        chk_eq("mrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk_eq("mrst_nodone", 64'(ndone), 64'd0);
        run_op(8'd200, 8'd200, 1'b0, 16'h9C40, "after_rst");

        cyc = 0;
        while (cfg_finished < 6 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq("cfg_all_done", 64'(cfg_finished), 64'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
